// File: rtl/sp_ram_rd_streamer_if.sv
// Bundle of the control, RAM-port and stream signals of sp_ram_rd_streamer.
// The streamer connects through the master modport; the environment (RAM,
// stream sink, burst requester) uses the slave modport.
// m_last exists only when SP_RD_LAST_EN is defined.
interface sp_ram_rd_streamer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH:0]   length;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
`ifdef SP_RD_LAST_EN
  logic                  m_last;
`endif

  modport master (
    input  start, base_addr, length, ram_rdata, m_ready,
`ifdef SP_RD_LAST_EN
    output m_last,
`endif
    output busy, done, ram_addr, ram_we, m_data, m_valid
  );

  modport slave (
    output start, base_addr, length, ram_rdata, m_ready,
`ifdef SP_RD_LAST_EN
    input  m_last,
`endif
    input  busy, done, ram_addr, ram_we, m_data, m_valid
  );
endinterface

// File: rtl/sp_ram_rd_streamer.sv
// sp_ram_rd_streamer: reads a burst of `length` words from a single-port RAM
// (1-cycle read latency, RAM_DEPTH = 1 << ADDR_WIDTH, addresses wrap) starting
// at base_addr and streams them out over a valid/ready port. A 2-entry output
// buffer (output register + skid entry) absorbs backpressure; reads are only
// issued while buffered words + reads in flight leave room for the result.
// Optional feature: define SP_RD_LAST_EN to add m_last on the final word.
module sp_ram_rd_streamer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                   wclk,
  input  logic                   rst_n,
  sp_ram_rd_streamer_if.master   bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH:0]   issued_q, issued_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic                  skid_vld_q, skid_vld_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
`ifdef SP_RD_LAST_EN
  logic                  m_last_q, m_last_d;
`endif

  logic                  pop;
  logic [2:0]            occ;

  // State, address, buffer and status registers; everything clears on reset
  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ram_addr_q  <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      inflight_q  <= 1'b0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      skid_data_q <= '0;
      skid_vld_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef SP_RD_LAST_EN
      m_last_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ram_addr_q  <= ram_addr_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      inflight_q  <= inflight_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      skid_data_q <= skid_data_d;
      skid_vld_q  <= skid_vld_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef SP_RD_LAST_EN
      m_last_q    <= m_last_d;
`endif
    end
  end

  // Next-state: buffer movement, read issue and burst sequencing
  always_comb begin
    state_d     = state_q;
    ram_addr_d  = ram_addr_q;
    len_d       = len_q;
    issued_d    = issued_q;
    inflight_d  = 1'b0;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q;
    skid_data_d = skid_data_q;
    skid_vld_d  = skid_vld_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    pop = m_valid_q && bus.m_ready;
    // Occupancy after this cycle's hand-off; a new read needs a free slot
    occ = 3'(m_valid_q) + 3'(skid_vld_q) + 3'(inflight_q) - 3'(pop);

    // Returning read data lands behind anything already buffered
    if (pop) begin
      if (skid_vld_q) begin
        m_data_d   = skid_data_q;
        m_valid_d  = 1'b1;
        skid_vld_d = inflight_q;
        if (inflight_q) skid_data_d = bus.ram_rdata;
      end else if (inflight_q) begin
        m_data_d  = bus.ram_rdata;
        m_valid_d = 1'b1;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (inflight_q) begin
      if (!m_valid_q) begin
        m_data_d  = bus.ram_rdata;
        m_valid_d = 1'b1;
      end else begin
        skid_data_d = bus.ram_rdata;
        skid_vld_d  = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.length == '0) begin
            done_d = 1'b1;
          end else begin
            state_d    = RUN;
            busy_d     = 1'b1;
            ram_addr_d = bus.base_addr;
            len_d      = bus.length;
            issued_d   = '0;
          end
        end
      end
      RUN: begin
        if (occ < 3'd2) begin
          inflight_d = 1'b1;
          ram_addr_d = ram_addr_q + ADDR_WIDTH'(1);
          issued_d   = issued_q + (ADDR_WIDTH+1)'(1);
          if (issued_d == len_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && !skid_vld_q && !inflight_q) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef SP_RD_LAST_EN
    // In DRAIN a lone buffered word with nothing behind it is the final one
    m_last_d = (state_d == DRAIN) && m_valid_d && !skid_vld_d && !inflight_d;
`endif
  end

  assign bus.ram_addr = ram_addr_q;
  assign bus.ram_we   = 1'b0;
  assign bus.m_data   = m_data_q;
  assign bus.m_valid  = m_valid_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
`ifdef SP_RD_LAST_EN
  assign bus.m_last   = m_last_q;
`endif

endmodule

// File: tb/tb_sp_ram_rd_streamer.sv
// Directed bench for sp_ram_rd_streamer with a scoreboard queue of expected
// stream words. Optional m_last checks follow SP_RD_LAST_EN.
module tb_sp_ram_rd_streamer;
  localparam int DW    = 16;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic wclk  = 1'b0;
  logic rst_n = 1'b1;
  always #5 wclk = ~wclk;

  sp_ram_rd_streamer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  sp_ram_rd_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .wclk  (wclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [DW-1:0] mem [DEPTH];
  always @(posedge wclk) bus.ram_rdata <= mem[bus.ram_addr];

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;
  int done_cnt = 0;
  int xfer_cnt = 0;
  logic [DW-1:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: score a hand-off happening at the coming edge, then advance.
  task automatic step();
    logic          hold_pend;
    logic [DW-1:0] hold_data;
    logic [DW-1:0] e;
    if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
      xfer_cnt++;
      check("sb_word_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("m_data", 32'(bus.m_data), 32'(e));
`ifdef SP_RD_LAST_EN
        check("m_last", 32'(bus.m_last), 32'(exp_q.size() == 0));
`endif
      end
    end
    hold_pend = (bus.m_valid === 1'b1) && (bus.m_ready === 1'b0);
    hold_data = bus.m_data;
    @(posedge wclk);
    #1;
    if (hold_pend) begin
      check("stall_valid", 32'(bus.m_valid), 32'd1);
      check("stall_data", 32'(bus.m_data), 32'(hold_data));
    end
    if (bus.done === 1'b1) done_cnt++;
  endtask

  task automatic start_burst(input int base, input int len);
    bus.start     = 1'b1;
    bus.base_addr = AW'(base);
    bus.length    = (AW+1)'(len);
    for (int i = 0; i < len; i++)
      exp_q.push_back(16'h1000 + 16'((base + i) % DEPTH));
    step();
    bus.start = 1'b0;
  endtask

  // mode 0: ready always high; mode 1: ready pattern 1,0,0,1,0,0,...
  task automatic run_until_done(input string tag, input int budget, input int mode);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      bus.m_ready = (mode == 0) ? 1'b1 : ((n % 3) == 0);
      step();
      n++;
    end
    check({tag, "_done_seen"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_busy_low"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int d0;
    int x0;
    int n;
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'h1000 + 16'(i);
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.length    = '0;
    bus.m_ready   = 1'b1;

    // Asynchronous reset: outputs clear before any clock edge
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_valid", 32'(bus.m_valid), 32'd0);
    check("rst_data", 32'(bus.m_data), 32'd0);
    check("rst_addr", 32'(bus.ram_addr), 32'd0);
    check("ram_we", 32'(bus.ram_we), 32'd0);
    @(posedge wclk);
    @(posedge wclk);
    #1 rst_n = 1'b1;

    // Burst base 2 length 4: 2-cycle latency, back-to-back words
    d0 = done_cnt;
    start_burst(2, 4);
    check("s1_busy", 32'(bus.busy), 32'd1);
    check("s1_first_addr", 32'(bus.ram_addr), 32'd2);
    step();
    check("s1_lat_valid0", 32'(bus.m_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("s1_valid_run", 32'(bus.m_valid), 32'd1);
    end
    step();
    check("s1_valid_end", 32'(bus.m_valid), 32'd0);
    check("s1_done", 32'(bus.done), 32'd1);
    check("s1_busy_end", 32'(bus.busy), 32'd0);
    step();
    check("s1_done_once", 32'(done_cnt - d0), 32'd1);
    check("s1_sb_empty", 32'(exp_q.size()), 32'd0);

    // Wrap-around: base 6 length 4
    start_burst(6, 4);
    run_until_done("s2", 40, 0);

    // Full depth with backpressure
    bus.m_ready = 1'b1;
    start_burst(0, 8);
    run_until_done("s3", 120, 1);
    bus.m_ready = 1'b1;

    // Zero length: done next cycle, no words, busy stays low
    start_burst(3, 0);
    check("s4_done", 32'(bus.done), 32'd1);
    check("s4_busy", 32'(bus.busy), 32'd0);
    check("s4_valid", 32'(bus.m_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("s4_idle_valid", 32'(bus.m_valid), 32'd0);
      check("s4_idle_busy", 32'(bus.busy), 32'd0);
      check("s4_idle_done", 32'(bus.done), 32'd0);
    end

    // Start while busy is ignored
    d0 = done_cnt;
    start_burst(1, 5);
    step();
    bus.start     = 1'b1;
    bus.base_addr = AW'(4);
    bus.length    = (AW+1)'(2);
    step();
    bus.start = 1'b0;
    check("s5_busy", 32'(bus.busy), 32'd1);
    run_until_done("s5", 40, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("s5_no_extra", 32'(bus.m_valid), 32'd0);
    end
    check("s5_one_done", 32'(done_cnt - d0), 32'd1);

    // Reset after the second word of a length-8 burst
    start_burst(0, 8);
    x0 = xfer_cnt;
    n  = 0;
    while (xfer_cnt < x0 + 2 && n < 20) begin
      step();
      n++;
    end
    check("s6_two_words", 32'(xfer_cnt - x0), 32'd2);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check("s6_rst_busy", 32'(bus.busy), 32'd0);
    check("s6_rst_valid", 32'(bus.m_valid), 32'd0);
    check("s6_rst_data", 32'(bus.m_data), 32'd0);
    check("s6_rst_addr", 32'(bus.ram_addr), 32'd0);
    check("s6_rst_done", 32'(bus.done), 32'd0);
    exp_q.delete();
    step();
    step();
    rst_n = 1'b1;
    start_burst(5, 3);
    check("s6_restart_busy", 32'(bus.busy), 32'd1);
    check("s6_restart_addr", 32'(bus.ram_addr), 32'd5);
    run_until_done("s6", 40, 0);
    check("s6_no_abandoned_done", 32'(done_cnt - d0), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/sp_ram_rd_streamer.md
SP_RAM_RD_STREAMER -- requirements
Module: sp_ram_rd_streamer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, RAM word width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 3, RAM address width; RAM_DEPTH = 1 << ADDR_WIDTH.
REQ-003 The block SHALL have port wclk, input, 1, the single clock; all logic rising-edge.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1, one-cycle request to begin a burst; sampled only in IDLE.
REQ-006 The block SHALL have port base_addr, input, ADDR_WIDTH, first RAM address; captured with start.
REQ-007 The block SHALL have port length, input, ADDR_WIDTH+1, word count 0..RAM_DEPTH; captured with start.
REQ-008 The block SHALL have port busy, output, 1, high from the accepted start until the last word is handed off.
REQ-009 The block SHALL have port done, output, 1, one-cycle pulse when a burst completes.
REQ-010 The block SHALL have port ram_addr, output, ADDR_WIDTH, RAM address, registered.
REQ-011 The block SHALL have port ram_we, output, 1, RAM write enable, constant 0.
REQ-012 The block SHALL have port ram_rdata, input, DATA_WIDTH, RAM read data, valid one cycle after ram_addr is presented.
REQ-013 The block SHALL have port m_data, output, DATA_WIDTH, stream data.
REQ-014 The block SHALL have port m_valid, output, 1, stream valid.
REQ-015 The block SHALL have port m_ready, input, 1, stream ready; a transfer occurs when m_valid and m_ready are both high.

Function
REQ-016 The FSM SHALL have three states: IDLE, RUN (reads issuing) and DRAIN (all reads issued, buffer not yet empty).
REQ-017 A start in IDLE with length = 0 SHALL pulse done on the next cycle, leave busy low and issue no reads.
REQ-018 A start in IDLE with length > 0 SHALL enter RUN, and the first read SHALL be issued in the same cycle as the transition (ram_addr = base_addr).
REQ-019 Each issued read SHALL increment ram_addr by 1 modulo RAM_DEPTH; wrap from RAM_DEPTH-1 to 0 is legal.
REQ-020 The block SHALL own a 2-entry output buffer, and a read SHALL issue only when (words buffered + reads in flight) < 2, so no data is lost under backpressure.
REQ-021 Captured ram_rdata SHALL appear on m_data in RAM address order, with no gaps and no duplicates.
REQ-022 m_data and m_valid SHALL be registered; m_data SHALL hold stable while m_valid is high and m_ready is low.
REQ-023 With m_ready held high, minimum latency SHALL be 2 cycles from the accepted start to the first m_valid, and throughput SHALL be 1 word per cycle.
REQ-024 After issuing the length-th read, the FSM SHALL go RUN -> DRAIN; DRAIN -> IDLE on the final transfer, with done pulsing in the cycle after that transfer.
REQ-025 start while busy SHALL be ignored; the parameters of the burst in progress SHALL remain unchanged.
REQ-026 length = RAM_DEPTH SHALL read every address exactly once, starting at base_addr.

Reset
REQ-027 Assertion of rst_n low SHALL immediately set state = IDLE, busy = 0, done = 0, m_valid = 0, m_data = 0, ram_addr = 0, and clear the buffer and in-flight count.
REQ-028 Reset mid-burst SHALL abandon the burst, with no done pulse.
REQ-029 After rst_n deasserts, the first start SHALL be accepted on the first rising edge.

Configuration
REQ-030 With macro SP_RD_LAST_EN defined, the block SHALL add output m_last (1 bit, reset 0), high together with m_valid on the final word of each burst.
REQ-031 With SP_RD_LAST_EN undefined, m_last SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-032 Scenario: RAM preloaded with mem[i] = 16'h1000+i; start, base 2, length 4, m_ready = 1 -> m_data 1002, 1003, 1004, 1005 on consecutive cycles; done pulses once; m_last (if enabled) on 1005.
REQ-033 Scenario: base 6, length 4 -> m_data 1006, 1007, 1000, 1001 (wrap-around).
REQ-034 Scenario: base 0, length 8, m_ready toggling 1,0,0,1,... -> all 8 words in order, none lost, m_data stable while stalled.
REQ-035 Scenario: length 0 -> done pulses one cycle later, m_valid never asserts, busy stays 0.
REQ-036 Scenario: second start pulsed during a length-5 burst -> ignored; exactly 5 words and one done.
REQ-037 Scenario: rst_n low after the 2nd word of a length-8 burst -> all outputs at reset values immediately, no done; a new start then runs normally.
